adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

Serial register-port responder for the ADC configuration link: the device-side end of the 24-bit sen/sclk/sdin/sdout frame that the AXI-lite ADC controller issues. It oversamples the serial pins in the system clock domain, decodes the 8-bit command and 16-bit data, and updates a local register file on writes. On reads it shifts register contents back on sdout. It serves as the ADC register-map model in system benches and as the configuration endpoint in loopback builds.

## Interface
- NUM_REGS, 16: implemented registers at addresses 0x00..NUM_REGS-1.
- DATA_W, 16: register width; fixed frame data field.
- SYNC_STAGES, 2: synchronizer flops on sen/sclk/sdin, minimum 2.

- clk  in  1  system clock; every flop is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sen  in  1  frame enable, active low.
- sclk  in  1  serial clock, idle low, asynchronous to clk.
- sdin  in  1  serial data in, MSB first.
- sdout  out  1  serial read data.
- sdout_oe  out  1  high while sdout carries read data.
- busy  out  1  synchronized sen is low.
- reg_wr_pulse  out  1  one-cycle strobe per committed register write.
- reg_wr_addr  out  8  address of the committed write.
- reg_wr_data  out  DATA_W  data of the committed write.
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg i occupies bits [i*DATA_W +: DATA_W].
- frame_err  out  1  one-cycle strobe when a frame aborts.

## Operation
- Frame format, MSB first: cmd[7:0] then data[15:0]. cmd[7] is 1 for read and 0 for write. cmd[6:0] is the register address.
- sen, sclk and sdin each pass through a SYNC_STAGES synchronizer. sclk rise and fall are edge-detected on the synchronized value.
- Bits are sampled on the sclk rising edge. sdout changes on the sclk falling edge.
- FSM states:
  - IDLE: wait for synchronized sen to go low, then enter CMD and clear the bit counter.
  - CMD: shift in 8 bits. On the 8th rise, latch cmd and enter DATA. On a read, snapshot the addressed register (0 if unimplemented) into the output shifter.
  - DATA: 16 rises.
    - Write: shift sdin in. On the 16th rise, commit the write and enter DONE.
    - Read: drive the shifter MSB on each fall; sdin is ignored. After the 16th rise, enter DONE.
  - DONE: ignore further sclk edges until sen goes high, then enter IDLE.
- Write commit:
  - Implemented address: update the register, and pulse reg_wr_pulse with reg_wr_addr/reg_wr_data.
  - Unimplemented address (cmd[6:0] >= NUM_REGS): no register change and no pulse.
- Soft reset: a write of data bit0=1 to address 0x00 clears all registers, including reg 0, on the commit cycle. reg_wr_pulse still fires with the written data.
- Abort: sen goes high in CMD or DATA. Return to IDLE, pulse frame_err for one cycle, and do not commit or change any register.
- sdout_oe is high from the first fall in the read DATA phase until sen rises or the FSM leaves DATA/DONE. sdout is 0 whenever sdout_oe is 0.
- After reset, a frame starts only on a fresh sen falling edge. If sen is already low when reset releases, the block waits in IDLE for sen high first.

## Timing
- Reset values: sdout=0, sdout_oe=0, busy=0, reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0, regs_flat=0, frame_err=0, FSM=IDLE.
- A pin edge is visible internally SYNC_STAGES+1 clk cycles after the first clk edge that samples it.
- sclk high and low times must each be at least SYNC_STAGES+2 clk cycles. sen setup to the first sclk rise has the same minimum.
- sdin must be stable across the sampling window, i.e. from the sclk rise until SYNC_STAGES+1 cycles later.
- Write latency: regs_flat and reg_wr_pulse update on the clk cycle after the 24th rise is detected.
- Read latency: sdout is updated on the cycle after each detected fall, SYNC_STAGES+2 cycles after the pin fall. Bit 15 appears after the first fall following the 8th rise.
- Simultaneous events:
  - Reset wins over commit.
  - A sen rise detected in the same cycle as the 24th rise counts as an abort; no commit.
  - A commit and a soft reset in one frame resolve to soft reset.
- Reset mid-frame returns to IDLE with no commit and no frame_err.

## Test plan
- Write 0x05 <= 0xBEEF: regs_flat[5] = 0xBEEF, and reg_wr_pulse is high for exactly 1 cycle with addr 0x05, data 0xBEEF. All other registers stay 0.
- Read cmd 0x85 after that write: sdout shifts 1011_1110_1110_1111 and sdout_oe stays high through the 16 bits. No register changes.
- Abort: sen goes high after 12 sclk rises of a write to 0x03. frame_err pulses once, regs_flat[3] is unchanged, and the next full frame works normally.
- Unimplemented address: write 0x20 <= 0x1234 gives no reg_wr_pulse and no register change. Read 0xA0 returns 0x0000.
- Soft reset: preload regs 1..3, then write 0x00 <= 0x0001. All regs read 0 and reg_wr_pulse fires with data 0x0001.
- reset asserted after 10 bits of a write, with sen held low: no commit and no frame_err. A frame starts only after sen goes high and then low again.

Source files
------------

// File: rtl/adc_spi_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_responder_if
// Purpose  : sen/sclk/sdin/sdout link between the ADC controller and responder
// Revision : 1.0 - initial release
// ============================================================================
interface adc_spi_responder_if;
    logic sen;
    logic sclk;
    logic sdin;
    logic sdout;
    logic sdout_oe;

    modport master (output sen, sclk, sdin, input sdout, sdout_oe);
    modport slave  (input sen, sclk, sdin, output sdout, sdout_oe);
endinterface
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_responder
// Purpose  : oversampled 24-bit serial register-port responder with local regs
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_responder #(
    parameter int NUM_REGS    = 16,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    adc_spi_responder_if.slave         spi,
    output logic                       busy,
    output logic                       reg_wr_pulse,
    output logic [7:0]                 reg_wr_addr,
    output logic [DATA_W-1:0]          reg_wr_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       frame_err
);
    localparam int         c_AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] c_NUM_REGS = 8'(NUM_REGS);
    localparam logic [3:0] c_CMD_LAST = 4'd7;
    localparam logic [3:0] c_DAT_LAST = 4'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sen_sync, r_sclk_sync, r_sdin_sync, r_sync_vld;
    logic                   r_sclk_d, r_armed;
    logic                   w_sen, w_sclk, w_sdin, w_rise, w_fall;

    logic [3:0]        r_cnt;
    logic [DATA_W-2:0] r_shift;
    logic [7:0]        r_cmd;
    logic [DATA_W-1:0] r_tx;
    logic              r_sdout, r_oe, r_pulse, r_ferr;
    logic [7:0]        r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              w_cmd_done, w_commit, w_abort;
    logic [7:0]        w_cmd_word;
    logic [DATA_W-1:0] w_data_word;
    logic              w_snap_ok, w_wr_ok, w_soft;

    // sen chain resets high so busy stays low; r_armed blocks a frame until sen is really seen high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sen_sync  <= '1;
            r_sclk_sync <= '0;
            r_sdin_sync <= '0;
            r_sync_vld  <= '0;
            r_sclk_d    <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sen_sync  <= {r_sen_sync[SYNC_STAGES-2:0], spi.sen};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            r_sdin_sync <= {r_sdin_sync[SYNC_STAGES-2:0], spi.sdin};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= w_sclk;
            if (r_sync_vld[SYNC_STAGES-1] && w_sen) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sen  = r_sen_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdin = r_sdin_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_d;
    assign w_fall = ~w_sclk & r_sclk_d;

    assign w_cmd_word  = {r_shift[6:0], w_sdin};
    assign w_data_word = {r_shift, w_sdin};
    assign w_snap_ok   = ({1'b0, w_cmd_word[6:0]} < c_NUM_REGS);
    assign w_wr_ok     = ({1'b0, r_cmd[6:0]} < c_NUM_REGS);
    assign w_soft      = (r_cmd[6:0] == 7'd0) && w_data_word[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // sen high in CMD/DATA is checked first so it beats a coincident final rise
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_done  = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && !w_sen) w_state_nxt = S_CMD;
            end
            S_CMD: begin
                if (w_sen) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_rise && r_cnt == c_CMD_LAST) begin
                    w_cmd_done  = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_sen) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_rise && r_cnt == c_DAT_LAST) begin
                    w_commit    = ~r_cmd[7];
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_sen) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_cmd     <= '0;
            r_tx      <= '0;
            r_sdout   <= 1'b0;
            r_oe      <= 1'b0;
            r_pulse   <= 1'b0;
            r_ferr    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_pulse <= 1'b0;
            r_ferr  <= w_abort;

            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if ((r_state == S_CMD || r_state == S_DATA) && w_rise) begin
                r_cnt   <= w_cmd_done ? 4'd0 : r_cnt + 4'd1;
                r_shift <= {r_shift[DATA_W-3:0], w_sdin};
            end

            if (w_cmd_done) begin
                r_cmd <= w_cmd_word;
                if (w_cmd_word[7]) begin
                    r_tx <= w_snap_ok ? r_regs[w_cmd_word[c_AW-1:0]] : '0;
                end
            end

            if (r_state == S_DATA && r_cmd[7] && !w_sen && w_fall) begin
                r_sdout <= r_tx[DATA_W-1];
                r_tx    <= {r_tx[DATA_W-2:0], 1'b0};
                r_oe    <= 1'b1;
            end

            if (w_state_nxt == S_IDLE) begin
                r_sdout <= 1'b0;
                r_oe    <= 1'b0;
            end

            if (w_commit && w_wr_ok) begin
                r_pulse   <= 1'b1;
                r_wr_addr <= {1'b0, r_cmd[6:0]};
                r_wr_data <= w_data_word;
                if (w_soft) begin
                    for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
                end else begin
                    r_regs[r_cmd[c_AW-1:0]] <= w_data_word;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign spi.sdout    = r_sdout;
    assign spi.sdout_oe = r_oe;
    assign busy         = ~w_sen;
    assign reg_wr_pulse = r_pulse;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;
    assign frame_err    = r_ferr;
endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_responder
// Purpose  : directed self-checking bench for adc_spi_responder
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_responder;
    localparam int c_NR = 16;
    localparam int c_DW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 busy, reg_wr_pulse, frame_err;
    logic [7:0]           reg_wr_addr;
    logic [c_DW-1:0]      reg_wr_data;
    logic [c_NR*c_DW-1:0] regs_flat;

    always #5 clk = ~clk;

    adc_spi_responder_if spi_if ();

    adc_spi_responder #(
        .NUM_REGS    (c_NR),
        .DATA_W      (c_DW),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi_if),
        .busy         (busy),
        .reg_wr_pulse (reg_wr_pulse),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .regs_flat    (regs_flat),
        .frame_err    (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         n_pulse = 0;
    int         n_ferr  = 0;
    logic [7:0] last_addr = '0;
    logic [15:0] last_data = '0;

    always @(negedge clk) begin
        if (reg_wr_pulse) begin
            n_pulse++;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (frame_err) n_ferr++;
    end

    logic [c_NR*c_DW-1:0] m_flat = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each bit: sdin set with sclk low for 8 clks, read bit sampled just before the rise, sclk high 8 clks
    task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits,
                             input bit do_fall, input bit do_rise,
                             output logic [15:0] rd, output int oe_lo);
        logic [23:0] w;
        w     = {cmd, data};
        rd    = '0;
        oe_lo = 0;
        if (do_fall) begin
            spi_if.sen = 1'b0;
            wait_clks(8);
        end
        for (int i = 0; i < nbits; i++) begin
            spi_if.sdin = w[23-i];
            wait_clks(8);
            if (i >= 8) begin
                rd = {rd[14:0], spi_if.sdout};
                if (!spi_if.sdout_oe) oe_lo++;
            end
            spi_if.sclk = 1'b1;
            wait_clks(8);
            spi_if.sclk = 1'b0;
        end
        wait_clks(8);
        if (do_rise) begin
            spi_if.sen = 1'b1;
            wait_clks(8);
        end
        spi_if.sdin = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [15:0] data);
        logic [15:0] rd;
        int          oe_lo;
        spi_frame(addr, data, 24, 1'b1, 1'b1, rd, oe_lo);
    endtask

    initial begin
        logic [15:0] rd;
        int          oe_lo;
        int          p0, f0;

        reset       = 1'b1;
        spi_if.sen  = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.sdin = 1'b0;
        wait_clks(4);

        chk("rst_sdout",    256'(spi_if.sdout),    256'(0));
        chk("rst_oe",       256'(spi_if.sdout_oe), 256'(0));
        chk("rst_busy",     256'(busy),            256'(0));
        chk("rst_pulse",    256'(reg_wr_pulse),    256'(0));
        chk("rst_addr",     256'(reg_wr_addr),     256'(0));
        chk("rst_data",     256'(reg_wr_data),     256'(0));
        chk("rst_regs",     256'(regs_flat),       256'(0));
        chk("rst_ferr",     256'(frame_err),       256'(0));

        reset = 1'b0;
        wait_clks(8);

        // write 0x05 <= 0xBEEF
        p0 = n_pulse;
        do_write(8'h05, 16'hBEEF);
        m_flat[5*16 +: 16] = 16'hBEEF;
        chk("wr5_pulses", 256'(n_pulse - p0), 256'(1));
        chk("wr5_addr",   256'(last_addr),    256'(8'h05));
        chk("wr5_data",   256'(last_data),    256'(16'hBEEF));
        chk("wr5_regs",   256'(regs_flat),    256'(m_flat));

        // read back 0x85
        p0 = n_pulse;
        spi_frame(8'h85, 16'h0000, 24, 1'b1, 1'b1, rd, oe_lo);
        chk("rd5_data",    256'(rd),             256'(16'hBEEF));
        chk("rd5_oe_lo",   256'(oe_lo),          256'(0));
        chk("rd5_pulses",  256'(n_pulse - p0),   256'(0));
        chk("rd5_regs",    256'(regs_flat),      256'(m_flat));
        chk("rd5_oe_end",  256'(spi_if.sdout_oe), 256'(0));
        chk("rd5_sdo_end", 256'(spi_if.sdout),   256'(0));

        // abort after 12 rises of a write to 0x03, then a normal frame
        p0 = n_pulse;
        f0 = n_ferr;
        spi_frame(8'h03, 16'h7777, 12, 1'b1, 1'b1, rd, oe_lo);
        chk("abort_ferr",   256'(n_ferr - f0),  256'(1));
        chk("abort_pulses", 256'(n_pulse - p0), 256'(0));
        chk("abort_regs",   256'(regs_flat),    256'(m_flat));
        p0 = n_pulse;
        do_write(8'h03, 16'h1357);
        m_flat[3*16 +: 16] = 16'h1357;
        chk("after_abort_pulses", 256'(n_pulse - p0), 256'(1));
        chk("after_abort_regs",   256'(regs_flat),    256'(m_flat));

        // unimplemented address
        p0 = n_pulse;
        do_write(8'h20, 16'h1234);
        chk("unimpl_pulses", 256'(n_pulse - p0), 256'(0));
        chk("unimpl_regs",   256'(regs_flat),    256'(m_flat));
        spi_frame(8'hA0, 16'h0000, 24, 1'b1, 1'b1, rd, oe_lo);
        chk("unimpl_rd",     256'(rd),           256'(16'h0000));

        // soft reset via reg 0 bit 0
        do_write(8'h01, 16'h1111);
        do_write(8'h02, 16'h2222);
        do_write(8'h03, 16'h3333);
        m_flat[1*16 +: 16] = 16'h1111;
        m_flat[2*16 +: 16] = 16'h2222;
        m_flat[3*16 +: 16] = 16'h3333;
        chk("preload_regs", 256'(regs_flat), 256'(m_flat));
        p0 = n_pulse;
        do_write(8'h00, 16'h0001);
        m_flat = '0;
        chk("soft_pulses", 256'(n_pulse - p0), 256'(1));
        chk("soft_addr",   256'(last_addr),    256'(8'h00));
        chk("soft_data",   256'(last_data),    256'(16'h0001));
        chk("soft_regs",   256'(regs_flat),    256'(m_flat));
        spi_frame(8'h82, 16'h0000, 24, 1'b1, 1'b1, rd, oe_lo);
        chk("soft_rd2",    256'(rd),           256'(16'h0000));

        // reset after 10 bits with sen held low
        do_write(8'h04, 16'h0A0A);
        m_flat[4*16 +: 16] = 16'h0A0A;
        chk("pre_rst_regs", 256'(regs_flat), 256'(m_flat));
        p0 = n_pulse;
        f0 = n_ferr;
        spi_frame(8'h04, 16'hABCD, 10, 1'b1, 1'b0, rd, oe_lo);
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(8);
        m_flat = '0;
        chk("mid_rst_ferr",   256'(n_ferr - f0),  256'(0));
        chk("mid_rst_pulses", 256'(n_pulse - p0), 256'(0));
        chk("mid_rst_regs",   256'(regs_flat),    256'(m_flat));
        chk("mid_rst_busy",   256'(busy),         256'(1));
        spi_frame(8'h06, 16'h4444, 24, 1'b0, 1'b0, rd, oe_lo);
        chk("stale_sen_pulses", 256'(n_pulse - p0), 256'(0));
        chk("stale_sen_regs",   256'(regs_flat),    256'(m_flat));
        spi_if.sen = 1'b1;
        wait_clks(8);
        do_write(8'h06, 16'h5555);
        m_flat[6*16 +: 16] = 16'h5555;
        chk("fresh_pulses", 256'(n_pulse - p0), 256'(1));
        chk("fresh_regs",   256'(regs_flat),    256'(m_flat));
        chk("fresh_ferr",   256'(n_ferr - f0),  256'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
